// File: rtl/queue_frame_parser_pkg.sv
// Shared token constants, parser state and word decoder for the
// frame parser, pattern-generator and camera stages.
package queue_frame_parser_pkg;

    localparam int          WORD_W     = 17;
    localparam int          MARKER_BIT = 16;
    localparam logic [16:0] TOK_SOF    = 17'h10000;
    localparam logic [16:0] TOK_SOL    = 17'h10001;
    localparam logic [16:0] TOK_EOF    = 17'h1FFFF;

    typedef enum logic [1:0] {
        WAIT_SOF,
        WAIT_SOL,
        PIXELS,
        WAIT_EOF
    } parser_state_t;

    typedef enum logic [2:0] {
        K_PIX,
        K_SOF,
        K_SOL,
        K_EOF,
        K_ILL
    } token_kind_t;

    function automatic token_kind_t decode_token(input logic [16:0] w);
        token_kind_t k;
        if (!w[MARKER_BIT]) begin
            k = K_PIX;
        end else if (w == TOK_SOF) begin
            k = K_SOF;
        end else if (w == TOK_SOL) begin
            k = K_SOL;
        end else if (w == TOK_EOF) begin
            k = K_EOF;
        end else begin
            k = K_ILL;
        end
        return k;
    endfunction

endpackage

// File: rtl/queue_read_skid.sv
// Two-entry skid buffer in front of a 1-cycle-latency FIFO, with
// read-issue throttling that still sustains one word per cycle.
module queue_read_skid
    import queue_frame_parser_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_empty,
    output logic              o_rd_en,
    input  logic [WORD_W-1:0] i_data,
    output logic              o_valid,
    output logic [WORD_W-1:0] o_data,
    input  logic              i_pop
);

    logic [WORD_W-1:0] r_mem [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic              r_inflight;
    logic [1:0]        r_count;
    logic              w_pop;
    logic [1:0]        w_level;

    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_mem[r_rd_ptr];
    assign w_pop   = i_pop && o_valid;

    // Occupancy after this cycle: stored words plus the word landing
    // now, minus the one leaving, so a full pipe can keep reading.
    assign w_level = r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    assign o_rd_en = !i_rst && !i_empty && (w_level < 2'd2);

    // Track in-flight read, capture returned words, advance pointers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mem[0]   <= '0;
            r_mem[1]   <= '0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_inflight <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            r_inflight <= o_rd_en;
            r_count    <= w_level;
            if (r_inflight) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
        end
    end

endmodule

// File: rtl/queue_frame_parser.sv
// Parses a SOF/SOL/pixel/EOF token stream from a FIFO into a
// valid/ready pixel stream. Optional macro: PARSER_ERR_STATS_EN.
module queue_frame_parser
    import queue_frame_parser_pkg::*;
#(
    parameter int FRAME_WIDTH    = 480,
    parameter int FRAME_HEIGHT   = 272,
    parameter bit EXPECT_MARKERS = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        queue_empty,
    output logic        queue_rd_en,
    input  logic [16:0] queue_data,
    output logic [15:0] pix_data,
    output logic [10:0] pix_x,
    output logic [10:0] pix_y,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        frame_start,
    output logic        frame_done,
    output logic        frame_error
`ifdef PARSER_ERR_STATS_EN
    ,
    output logic [7:0]  err_count
`endif
);

    localparam logic [10:0] LP_XMAX = 11'(FRAME_WIDTH - 1);
    localparam logic [10:0] LP_YMAX = 11'(FRAME_HEIGHT - 1);
    localparam parser_state_t LP_AFTER_SOF =
        EXPECT_MARKERS ? WAIT_SOL : PIXELS;

    parser_state_t r_state;
    parser_state_t w_state_nxt;
    logic [10:0]   r_x;
    logic [10:0]   r_y;
    logic [10:0]   w_x_nxt;
    logic [10:0]   w_y_nxt;
    logic [15:0]   r_pix_data;
    logic [10:0]   r_pix_x;
    logic [10:0]   r_pix_y;
    logic          r_pix_valid;
    logic          r_frame_start;
    logic          r_frame_done;
    logic          r_frame_error;
    logic          w_start;
    logic          w_done;
    logic          w_err;
    logic          w_pop;
    logic          w_load;
    logic          w_head_valid;
    logic [16:0]   w_head;
    logic          w_out_free;
    token_kind_t   w_kind;

    queue_read_skid u_skid (
        .i_clk   (clk),
        .i_rst   (reset),
        .i_empty (queue_empty),
        .o_rd_en (queue_rd_en),
        .i_data  (queue_data),
        .o_valid (w_head_valid),
        .o_data  (w_head),
        .i_pop   (w_pop)
    );

    assign w_kind     = decode_token(w_head);
    assign w_out_free = !r_pix_valid || pix_ready;

    // Parser state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= WAIT_SOF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, coordinates, pulses and skid pop for the head word.
    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_start     = 1'b0;
        w_done      = 1'b0;
        w_err       = 1'b0;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        if (w_head_valid) begin
            if (r_state == PIXELS && w_kind == K_PIX) begin
                if (w_out_free) begin
                    w_pop  = 1'b1;
                    w_load = 1'b1;
                    if (r_x == LP_XMAX) begin
                        w_x_nxt = '0;
                        if (r_y != LP_YMAX) begin
                            w_y_nxt     = r_y + 11'd1;
                            w_state_nxt = LP_AFTER_SOF;
                        end else if (EXPECT_MARKERS) begin
                            w_state_nxt = WAIT_EOF;
                        end else begin
                            w_done      = 1'b1;
                            w_state_nxt = WAIT_SOF;
                        end
                    end else begin
                        w_x_nxt = r_x + 11'd1;
                    end
                end
            end else begin
                w_pop = 1'b1;
                if (w_kind == K_SOF) begin
                    w_err       = (r_state != WAIT_SOF);
                    w_start     = 1'b1;
                    w_x_nxt     = '0;
                    w_y_nxt     = '0;
                    w_state_nxt = LP_AFTER_SOF;
                end else if (r_state == WAIT_SOF) begin
                    w_state_nxt = WAIT_SOF;
                end else if (r_state == WAIT_SOL && w_kind == K_SOL) begin
                    w_x_nxt     = '0;
                    w_state_nxt = PIXELS;
                end else if (r_state == WAIT_EOF && w_kind == K_EOF) begin
                    w_done      = 1'b1;
                    w_state_nxt = WAIT_SOF;
                end else begin
                    w_err       = 1'b1;
                    w_state_nxt = WAIT_SOF;
                end
            end
        end
    end

    // Coordinates and registered single-cycle frame pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x           <= '0;
            r_y           <= '0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_x           <= w_x_nxt;
            r_y           <= w_y_nxt;
            r_frame_start <= w_start;
            r_frame_done  <= w_done;
            r_frame_error <= w_err;
        end
    end

    // Output pixel register: load when free, hold while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pix_data  <= '0;
            r_pix_x     <= '0;
            r_pix_y     <= '0;
            r_pix_valid <= 1'b0;
        end else if (w_load) begin
            r_pix_data  <= w_head[15:0];
            r_pix_x     <= r_x;
            r_pix_y     <= r_y;
            r_pix_valid <= 1'b1;
        end else if (pix_ready) begin
            r_pix_valid <= 1'b0;
        end
    end

    assign pix_data    = r_pix_data;
    assign pix_x       = r_pix_x;
    assign pix_y       = r_pix_y;
    assign pix_valid   = r_pix_valid;
    assign frame_start = r_frame_start;
    assign frame_done  = r_frame_done;
    assign frame_error = r_frame_error;

`ifdef PARSER_ERR_STATS_EN
    logic [7:0] r_err_count;

    // Saturating count of frame_error pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_count <= '0;
        end else if (w_err && r_err_count != 8'hFF) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_queue_frame_parser.sv
// Randomized bench: two parsers (markers on / off) share each token
// stream and are compared against a stream-level reference model.
module tb_queue_frame_parser;
    import queue_frame_parser_pkg::*;

    localparam int W = 4;
    localparam int H = 2;
    localparam int M_HUNT = 0;
    localparam int M_SOL  = 1;
    localparam int M_ROW  = 2;
    localparam int M_EOF  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        q_empty [2];
    logic        q_rd    [2];
    logic [16:0] q_data  [2];
    logic [15:0] pd      [2];
    logic [10:0] px      [2];
    logic [10:0] py      [2];
    logic        pv      [2];
    logic        pr      [2];
    logic        fs      [2];
    logic        fd      [2];
    logic        fe      [2];
`ifdef PARSER_ERR_STATS_EN
    logic [7:0]  ec      [2];
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        queue_frame_parser #(
            .FRAME_WIDTH    (W),
            .FRAME_HEIGHT   (H),
            .EXPECT_MARKERS (g == 0)
        ) u_dut (
            .clk         (clk),
            .reset       (rst),
            .queue_empty (q_empty[g]),
            .queue_rd_en (q_rd[g]),
            .queue_data  (q_data[g]),
            .pix_data    (pd[g]),
            .pix_x       (px[g]),
            .pix_y       (py[g]),
            .pix_valid   (pv[g]),
            .pix_ready   (pr[g]),
            .frame_start (fs[g]),
            .frame_done  (fd[g]),
            .frame_error (fe[g])
`ifdef PARSER_ERR_STATS_EN
            ,
            .err_count   (ec[g])
`endif
        );
    end

    int checks = 0;
    int errors = 0;

    logic [16:0] stream [1024];
    int          slen;
    int          inj_at;
    int          inj_cnt;

    logic [15:0] e_d [2][1024];
    logic [10:0] e_x [2][1024];
    logic [10:0] e_y [2][1024];
    int e_n[2], e_start[2], e_done[2], e_err[2], e_both[2];

    logic [10:0] o_x [2][1024];
    logic [10:0] o_y [2][1024];
    int o_n[2], o_start[2], o_done[2], o_err[2], o_both[2];
    int done_pos[2];

    task automatic add(input logic [16:0] w);
        stream[slen] = w;
        slen++;
    endtask

    function automatic logic [16:0] rand_pix();
        logic [15:0] d;
        d = 16'($urandom);
        return {1'b0, d};
    endfunction

    function automatic logic [16:0] fault_word();
        logic [15:0] v;
        int sel;
        sel = int'($urandom_range(4));
        v = 16'($urandom_range(16'hFFFD, 2));
        case (sel)
            0: return {1'b1, v};
            1: return TOK_SOF;
            2: return TOK_EOF;
            3: return TOK_SOL;
            default: return rand_pix();
        endcase
    endfunction

    task automatic put(input logic [16:0] w);
        if (inj_cnt == inj_at) add(fault_word());
        inj_cnt++;
        add(w);
    endtask

    // style 0: marker frame, 1: marker-less frame,
    // 2: marker frame with one injected word, 3: garbage words
    task automatic gen_frame(input int style);
        inj_cnt = 0;
        inj_at  = (style == 2) ? int'($urandom_range(12, 1)) : -1;
        if (style == 3) begin
            repeat (int'($urandom_range(3, 1))) add(fault_word());
        end else begin
            put(TOK_SOF);
            for (int r = 0; r < H; r++) begin
                if (style != 1) put(TOK_SOL);
                for (int c = 0; c < W; c++) put(rand_pix());
            end
            if (style != 1) put(TOK_EOF);
        end
    endtask

    task automatic frame_std();
        add(TOK_SOF);
        for (int r = 0; r < H; r++) begin
            add(TOK_SOL);
            for (int c = 0; c < W; c++) add(rand_pix());
        end
        add(TOK_EOF);
    endtask

    // Reference: walk the stream with the frame grammar rules.
    task automatic model(input int k, input bit mk);
        int mode, x, y;
        logic [16:0] w;
        e_n[k] = 0; e_start[k] = 0; e_done[k] = 0;
        e_err[k] = 0; e_both[k] = 0;
        mode = M_HUNT; x = 0; y = 0;
        for (int i = 0; i < slen; i++) begin
            w = stream[i];
            if (mode == M_HUNT) begin
                if (w == TOK_SOF) begin
                    e_start[k]++; x = 0; y = 0;
                    mode = mk ? M_SOL : M_ROW;
                end
            end else if (w == TOK_SOF) begin
                e_err[k]++; e_start[k]++; e_both[k]++;
                x = 0; y = 0;
                mode = mk ? M_SOL : M_ROW;
            end else if (mode == M_SOL && w == TOK_SOL) begin
                x = 0; mode = M_ROW;
            end else if (mode == M_EOF && w == TOK_EOF) begin
                e_done[k]++; mode = M_HUNT;
            end else if (mode == M_ROW && !w[16]) begin
                e_d[k][e_n[k]] = w[15:0];
                e_x[k][e_n[k]] = 11'(x);
                e_y[k][e_n[k]] = 11'(y);
                e_n[k]++;
                if (x < W - 1) begin
                    x++;
                end else begin
                    x = 0;
                    if (y < H - 1) begin
                        y++;
                        mode = mk ? M_SOL : M_ROW;
                    end else if (mk) begin
                        mode = M_EOF;
                    end else begin
                        e_done[k]++; mode = M_HUNT;
                    end
                end
            end else begin
                e_err[k]++; mode = M_HUNT;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            q_empty[k] = 1'b1; pr[k] = 1'b0; q_data[k] = '0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Plays the stream into both DUTs, checking pixels on handshake
    // and hold-while-stalled; rmode 0 ready=1, 1 toggling, 2 random.
    task automatic run_stream(input int rmode, input int gap,
                              input int max_cyc, input bit drain);
        int rp[2];
        logic [16:0] pend[2];
        bit rdp[2], stall[2];
        logic [15:0] hd[2];
        logic [10:0] hx[2], hy[2];
        int idle, n;
        idle = 0;
        for (int k = 0; k < 2; k++) begin
            rp[k] = 0; stall[k] = 0; rdp[k] = 0; pend[k] = '0;
            o_n[k] = 0; o_start[k] = 0; o_done[k] = 0;
            o_err[k] = 0; o_both[k] = 0; done_pos[k] = -1;
        end
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                pr[k] = (rmode == 0) ? 1'b1 :
                        (rmode == 1) ? ((cyc % 2) == 0) :
                        (int'($urandom_range(99)) < 65);
                q_empty[k] = (rp[k] >= slen) ||
                             (int'($urandom_range(99)) < gap);
            end
            #1;
            for (int k = 0; k < 2; k++) begin
                if (stall[k]) begin
                    checks++;
                    if (pv[k] !== 1'b1 || pd[k] !== hd[k] ||
                        px[k] !== hx[k] || py[k] !== hy[k]) begin
                        errors++;
                        $display("FAIL hold dut%0d got v=%b d=%h x=%0d y=%0d want v=1 d=%h x=%0d y=%0d",
                                 k, pv[k], pd[k], px[k], py[k], hd[k], hx[k], hy[k]);
                    end
                end
                stall[k] = pv[k] && !pr[k];
                hd[k] = pd[k]; hx[k] = px[k]; hy[k] = py[k];
                if (fs[k]) o_start[k]++;
                if (fe[k]) o_err[k]++;
                if (fs[k] && fe[k]) o_both[k]++;
                if (fd[k]) begin
                    o_done[k]++;
                    done_pos[k] = o_n[k] + (pv[k] ? 1 : 0);
                end
                if (pv[k] && pr[k]) begin
                    n = o_n[k];
                    checks++;
                    if (n >= e_n[k]) begin
                        errors++;
                        $display("FAIL extra_pix dut%0d got pixel %0d want only %0d",
                                 k, n + 1, e_n[k]);
                    end else if (pd[k] !== e_d[k][n] || px[k] !== e_x[k][n] ||
                                 py[k] !== e_y[k][n]) begin
                        errors++;
                        $display("FAIL pix%0d dut%0d got d=%h x=%0d y=%0d want d=%h x=%0d y=%0d",
                                 n, k, pd[k], px[k], py[k],
                                 e_d[k][n], e_x[k][n], e_y[k][n]);
                    end
                    o_x[k][n] = px[k]; o_y[k][n] = py[k];
                    o_n[k]++;
                end
                rdp[k] = q_rd[k];
                if (q_rd[k]) begin
                    checks++;
                    if (rp[k] >= slen) begin
                        errors++;
                        $display("FAIL overread dut%0d got rd_en=1 want 0 (queue empty)", k);
                        pend[k] = 17'h1AAAA;
                    end else begin
                        pend[k] = stream[rp[k]];
                    end
                    rp[k]++;
                end
            end
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++)
                if (rdp[k]) q_data[k] = pend[k];
            if (rp[0] >= slen && rp[1] >= slen && !pv[0] && !pv[1])
                idle++;
            else
                idle = 0;
            if (idle > 8) break;
        end
        if (drain) begin
            checks++;
            if (idle <= 8) begin
                errors++;
                $display("FAIL timeout got busy after %0d cycles want drained", max_cyc);
            end
        end
    endtask

    task automatic check_counts(input string tag);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (o_n[k] !== e_n[k] || o_start[k] !== e_start[k] ||
                o_done[k] !== e_done[k] || o_err[k] !== e_err[k] ||
                o_both[k] !== e_both[k]) begin
                errors++;
                $display("FAIL %s_counts dut%0d got n=%0d s=%0d d=%0d e=%0d se=%0d want n=%0d s=%0d d=%0d e=%0d se=%0d",
                         tag, k, o_n[k], o_start[k], o_done[k], o_err[k], o_both[k],
                         e_n[k], e_start[k], e_done[k], e_err[k], e_both[k]);
            end
`ifdef PARSER_ERR_STATS_EN
            checks++;
            if (int'(ec[k]) !== ((e_err[k] > 255) ? 255 : e_err[k])) begin
                errors++;
                $display("FAIL %s_errcnt dut%0d got %0d want %0d", tag, k, ec[k], e_err[k]);
            end
`endif
        end
    endtask

    task automatic check_idle_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (q_rd[k] !== 1'b0 || pv[k] !== 1'b0 || fs[k] !== 1'b0 ||
                fd[k] !== 1'b0 || fe[k] !== 1'b0 || pd[k] !== 16'd0 ||
                px[k] !== 11'd0 || py[k] !== 11'd0) begin
                errors++;
                $display("FAIL %s dut%0d got rd=%b v=%b s=%b d=%b e=%b pd=%h x=%0d y=%0d want all 0",
                         tag, k, q_rd[k], pv[k], fs[k], fd[k], fe[k], pd[k], px[k], py[k]);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            q_empty[k] = 1'b0; pr[k] = 1'b1; q_data[k] = TOK_SOF;
        end
        repeat (3) @(negedge clk);
        #1;
        check_idle_zero("reset");
`ifdef PARSER_ERR_STATS_EN
        checks++;
        if (ec[0] !== 8'd0) begin
            errors++;
            $display("FAIL reset_errcnt got %0d want 0", ec[0]);
        end
`endif
    endtask

    task automatic test_basic();
        do_reset();
        slen = 0;
        frame_std();
        model(0, 1'b1); model(1, 1'b0);
        run_stream(0, 0, 400, 1'b1);
        check_counts("basic");
        checks++;
        if (o_n[0] != 8 || o_start[0] != 1 || o_done[0] != 1 || o_err[0] != 0) begin
            errors++;
            $display("FAIL basic_frame got n=%0d s=%0d d=%0d e=%0d want 8 1 1 0",
                     o_n[0], o_start[0], o_done[0], o_err[0]);
        end
        for (int i = 0; i < 8 && i < o_n[0]; i++) begin
            checks++;
            if (o_x[0][i] !== 11'(i % W) || o_y[0][i] !== 11'(i / W)) begin
                errors++;
                $display("FAIL basic_xy%0d got (%0d,%0d) want (%0d,%0d)",
                         i, o_x[0][i], o_y[0][i], i % W, i / W);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        slen = 0;
        frame_std();
        model(0, 1'b1); model(1, 1'b0);
        run_stream(1, 0, 400, 1'b1);
        check_counts("bp");
    endtask

    task automatic test_no_markers();
        do_reset();
        slen = 0;
        add(TOK_SOF);
        repeat (W * H) add(rand_pix());
        model(0, 1'b1); model(1, 1'b0);
        run_stream(0, 0, 400, 1'b1);
        check_counts("nomark");
        checks++;
        if (o_done[1] != 1 || done_pos[1] != W * H) begin
            errors++;
            $display("FAIL nomark_done got done=%0d at_pixel=%0d want 1 at %0d",
                     o_done[1], done_pos[1], W * H);
        end
    endtask

    task automatic test_restart();
        do_reset();
        slen = 0;
        add(TOK_SOF); add(TOK_SOL); add(rand_pix()); add(rand_pix());
        frame_std();
        model(0, 1'b1); model(1, 1'b0);
        run_stream(2, 20, 600, 1'b1);
        check_counts("restart");
        checks++;
        if (o_both[0] != 1 || o_n[0] != 10 ||
            o_x[0][2] !== 11'd0 || o_y[0][2] !== 11'd0) begin
            errors++;
            $display("FAIL restart got both=%0d n=%0d third=(%0d,%0d) want 1 10 (0,0)",
                     o_both[0], o_n[0], o_x[0][2], o_y[0][2]);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        slen = 0;
        add(TOK_SOF); add(TOK_SOL); add(rand_pix()); add(rand_pix());
        add(17'h10005);
        repeat (3) add(rand_pix());
        add(TOK_SOL); add(TOK_EOF);
        frame_std();
        model(0, 1'b1); model(1, 1'b0);
        run_stream(2, 20, 800, 1'b1);
        check_counts("illegal");
        checks++;
        if (o_err[0] != 1 || o_n[0] != 10 || o_done[0] != 1) begin
            errors++;
            $display("FAIL illegal got err=%0d n=%0d done=%0d want 1 10 1",
                     o_err[0], o_n[0], o_done[0]);
        end
    endtask

    task automatic test_reset_midrow();
        do_reset();
        slen = 0;
        frame_std();
        model(0, 1'b1); model(1, 1'b0);
        run_stream(0, 0, 6, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_idle_zero("midrow_rst");
        for (int k = 0; k < 2; k++) q_data[k] = 17'h0BEEF;
        @(negedge clk);
        rst = 1'b0;
        slen = 0;
        frame_std();
        model(0, 1'b1); model(1, 1'b0);
        run_stream(2, 10, 600, 1'b1);
        check_counts("midrow");
        checks++;
        if (o_n[0] < 1 || o_x[0][0] !== 11'd0 || o_y[0][0] !== 11'd0) begin
            errors++;
            $display("FAIL midrow_first got n=%0d (%0d,%0d) want (0,0)",
                     o_n[0], o_x[0][0], o_y[0][0]);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            do_reset();
            slen = 0;
            repeat (5) gen_frame(int'($urandom_range(3)));
            model(0, 1'b1); model(1, 1'b0);
            run_stream(2, 35, 3000, 1'b1);
            check_counts("random");
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            q_empty[k] = 1'b1; pr[k] = 1'b0; q_data[k] = '0;
        end
        slen = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_no_markers();
        test_restart();
        test_illegal();
        test_reset_midrow();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
